// File: rtl/rom_arbiter_if.sv
// Request/response bus of rom_arbiter together with its asynchronous ROM port.
// master = requesters plus ROM model; slave = the arbiter.
interface rom_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int ADDRW = $clog2(DEPTH);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [ADDRW-1:0]      rom_addr;
    logic [WIDTH-1:0]      rom_data;

    modport master (
        output req_valid, req_addr, rom_data,
        input  req_ready, rsp_valid, rsp_data, rom_addr
    );

    modport slave (
        input  req_valid, req_addr, rom_data,
        output req_ready, rsp_valid, rsp_data, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one asynchronous ROM between NREQ requesters, fixed latency 2.
// Define ROM_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module rom_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input logic         clk,
    input logic         rst_n,
    rom_arbiter_if.slave bus
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int IDXW  = $clog2(NREQ);
    localparam int SUMW  = IDXW + 2;

    // Handshake: request i transfers in a cycle where req_valid[i] && req_ready[i]; requesters
    // hold valid/addr until then. rsp_valid is a one-cycle strobe with no back-pressure.
    logic [IDXW-1:0]  r_last_grant;
    logic [ADDRW-1:0] r_rom_addr;
    logic             r_s1_valid;
    logic [IDXW-1:0]  r_s1_id;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;

    logic [NREQ-1:0]  w_rr_mask;
    logic             w_rr_any;
    logic [IDXW-1:0]  w_rr_idx;
    logic [SUMW-1:0]  w_sum;
    logic             w_gnt_any;
    logic [IDXW-1:0]  w_gnt_idx;
    logic             w_accept;
    logic             w_upd_last;

    // Scan from last_grant+1 upward with wrap; first masked-in requester wins.
    always_comb begin
        w_rr_any = 1'b0;
        w_rr_idx = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = SUMW'(r_last_grant) + SUMW'(k) + SUMW'(1);
            if (w_sum >= SUMW'(NREQ)) begin
                w_sum = w_sum - SUMW'(NREQ);
            end
            if (!w_rr_any && w_rr_mask[w_sum[IDXW-1:0]]) begin
                w_rr_any = 1'b1;
                w_rr_idx = w_sum[IDXW-1:0];
            end
        end
    end

`ifdef ROM_ARB_PRIO0_EN
    // Requester 0 bypasses the pointer and never moves it, so the others rotate among themselves.
    assign w_rr_mask = bus.req_valid & {{(NREQ-1){1'b1}}, 1'b0};

    always_comb begin
        w_gnt_any = bus.req_valid[0] | w_rr_any;
        w_gnt_idx = bus.req_valid[0] ? '0 : w_rr_idx;
    end

    assign w_upd_last = w_accept && (w_gnt_idx != '0);
`else
    assign w_rr_mask  = bus.req_valid;
    assign w_gnt_any  = w_rr_any;
    assign w_gnt_idx  = w_rr_idx;
    assign w_upd_last = w_accept;
`endif

    assign w_accept      = w_gnt_any & rst_n;
    assign bus.req_ready = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr   <= '0;
            r_last_grant <= IDXW'(NREQ - 1);
            r_s1_valid   <= 1'b0;
            r_s1_id      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_rom_addr <= bus.req_addr[w_gnt_idx*ADDRW +: ADDRW];
                r_s1_id    <= w_gnt_idx;
            end
            if (w_upd_last) begin
                r_last_grant <= w_gnt_idx;
            end
            r_s1_valid  <= w_accept;
            r_rsp_valid <= r_s1_valid ? (NREQ'(1) << r_s1_id) : '0;
            if (r_s1_valid) begin
                r_rsp_data <= bus.rom_data;
            end
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: behavioural round-robin/latency model checked every cycle,
// directed literal scenarios, then randomized request traffic with occasional resets.
module tb_rom_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int ADDRW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rom_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] rom_mem [DEPTH];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pointer, expected registered outputs, in-flight responses.
    logic [WIDTH-1:0] exp_q [$];
    int               id_q  [$];
    int               due_q [$];
    int               m_last = NREQ - 1;
    logic [WIDTH-1:0] m_data = '0;
    logic [ADDRW-1:0] m_addr = '0;
    logic [NREQ-1:0]  m_rv;
    int               m_g;

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef ROM_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int off = 1; off <= NREQ; off++) begin
            int i = (last + off) % NREQ;
`ifdef ROM_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            chk("rst_rom_addr", bus.rom_addr, 0);
            exp_q.delete();
            id_q.delete();
            due_q.delete();
            m_last = NREQ - 1;
            m_data = '0;
            m_addr = '0;
        end else begin
            m_rv = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                m_rv[id_q.pop_front()] = 1'b1;
                m_data = exp_q.pop_front();
            end
            chk("rsp_valid", bus.rsp_valid, m_rv);
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rom_addr", bus.rom_addr, m_addr);
            m_g = pick(bus.req_valid, m_last);
            chk("req_ready", bus.req_ready, (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
            if (m_g >= 0) begin
                m_addr = bus.req_addr[m_g*ADDRW +: ADDRW];
                exp_q.push_back(rom_mem[m_addr]);
                id_q.push_back(m_g);
                due_q.push_back(cyc + 2);
`ifdef ROM_ARB_PRIO0_EN
                if (m_g != 0)
`endif
                m_last = m_g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*ADDRW-1:0] a);
        bus.req_valid = v;
        bus.req_addr  = a;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        drive('0, '0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int              ord_a [8];
    int              ord_b [4];
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] v_now;
    int              dens;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = WIDTH'($urandom_range(0, 255));
        rom_mem[8'h10] = 8'hA5;
        rom_mem[8'hFF] = 8'h3C;
        rom_mem[8'h00] = 8'hC3;
        drive('0, '0);
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Single request: ready same cycle, response two cycles later.
        drive(4'b0001, 32'h0000_0010);
        settle();
        chk("t028_ready", bus.req_ready, 4'b0001);
        tick();
        drive('0, '0);
        settle();
        chk("t028_gap", bus.rsp_valid, 0);
        tick();
        settle();
        chk("t028_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t028_rsp_data", bus.rsp_data, 8'hA5);
        tick();

        // All four valid for 8 cycles.
`ifdef ROM_ARB_PRIO0_EN
        ord_a = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        ord_a = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        do_reset();
        drive(4'b1111, 32'h2322_2120);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t029_grant", bus.req_ready, 32'd1 << ord_a[k]);
            tick();
        end
        drive('0, '0);
        repeat (4) tick();

        // Requesters 1..3 rotate, then requester 0 joins.
        ord_b = '{1, 2, 3, 1};
        do_reset();
        drive(4'b1110, 32'h3332_3130);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t031_grant", bus.req_ready, 32'd1 << ord_b[k]);
            tick();
        end
        drive(4'b1111, 32'h3332_3130);
        settle();
`ifdef ROM_ARB_PRIO0_EN
        chk("t031_join", bus.req_ready, 4'b0001);
`else
        chk("t031_join", bus.req_ready, 4'b0100);
`endif
        tick();
        drive('0, '0);
        repeat (4) tick();

        // Reset one cycle after an acceptance discards the in-flight read.
        do_reset();
        drive(4'b0010, 32'h0000_4400);
        settle();
        chk("t032_ready", bus.req_ready, 4'b0010);
        tick();
        rst_n = 1'b0;
        settle();
        chk("t032_rst_ready", bus.req_ready, 0);
        tick();
        settle();
        chk("t032_rst_rsp", bus.rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        drive(4'b0110, 32'h0000_5050);
        settle();
        chk("t032_first", bus.req_ready, 4'b0010);
        chk("t032_no_rsp", bus.rsp_valid, 0);
        tick();
        drive('0, '0);
        repeat (4) tick();

        // Requester 2 alone: 0xFF then 0x00 back to back.
        do_reset();
        drive(4'b0100, 32'h00FF_0000);
        settle();
        chk("t033_ready_a", bus.req_ready, 4'b0100);
        tick();
        drive(4'b0100, 32'h0000_0000);
        settle();
        chk("t033_ready_b", bus.req_ready, 4'b0100);
        tick();
        drive('0, '0);
        settle();
        chk("t033_rsp_a_valid", bus.rsp_valid, 4'b0100);
        chk("t033_rsp_a_data", bus.rsp_data, 8'h3C);
        tick();
        settle();
        chk("t033_rsp_b_valid", bus.rsp_valid, 4'b0100);
        chk("t033_rsp_b_data", bus.rsp_data, 8'hC3);
        tick();
        repeat (2) tick();

        // Random traffic: requests hold until accepted, rare withdrawals and resets.
        for (int c = 0; c < 3000; c++) begin
            settle();
            acc = bus.req_ready;
            tick();
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            dens  = (c < 1500) ? 35 : 90;
            v_now = bus.req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (v_now[i] && acc[i]) v_now[i] = 1'b0;
                else if (v_now[i] && $urandom_range(0, 39) == 0) v_now[i] = 1'b0;
                if (!v_now[i] && $urandom_range(0, 99) < dens) begin
                    v_now[i] = 1'b1;
                    bus.req_addr[i*ADDRW +: ADDRW] = ADDRW'($urandom_range(0, DEPTH - 1));
                end
            end
            bus.req_valid = v_now;
        end
        rst_n = 1'b1;
        drive('0, '0);
        repeat (4) tick();
        settle();
        chk("drain", due_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter WIDTH, default 8: ROM data width in bits.
REQ-003 Parameter DEPTH, default 256: ROM word count; ADDRW = $clog2(DEPTH) is a derived localparam.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NREQ  per-requester read request.
REQ-007 req_addr  input  NREQ*ADDRW  per-requester address; requester i occupies bits [i*ADDRW +: ADDRW].
REQ-008 req_ready  output  NREQ  one-hot accept; request i is accepted in any cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  NREQ  one-hot, one-cycle response strobe.
REQ-010 rsp_data  output  WIDTH  read data, shared by all requesters; qualified by rsp_valid.
REQ-011 rom_addr  output  ADDRW  registered address to the asynchronous ROM.
REQ-012 rom_data  input  WIDTH  combinational ROM read data for rom_addr.

Function
REQ-013 Each cycle, at most one req_ready bit is high, combinationally selected from the current req_valid bits; req_ready is all-zero when req_valid is all-zero.
REQ-014 Round-robin selection: the search starts at index (last_grant+1) mod NREQ and ascends with wrap; the first valid index wins.
REQ-015 On acceptance of request i in cycle t: rom_addr <= req_addr[i], last_grant <= i, and a stage-1 tag (valid=1, id=i) is registered.
REQ-016 In cycle t+1, rsp_data <= rom_data and rsp_valid <= one-hot(id) are registered; the response is visible throughout cycle t+2 (fixed latency 2 from acceptance).
REQ-017 Fully pipelined: one acceptance per cycle is sustained; back-to-back acceptances produce back-to-back responses in acceptance order.
REQ-018 rom_addr holds its last value when no acceptance occurs; rsp_valid is 0 in any cycle not preceded, two cycles earlier, by an acceptance.
REQ-019 rsp_data holds its last value when rsp_valid is zero.
REQ-020 Requesters hold req_valid and req_addr stable until accepted; a request withdrawn before acceptance is dropped without side effect.
REQ-021 A single continuously valid requester is accepted every cycle.
REQ-022 last_grant updates only on acceptance.

Reset
REQ-023 While rst_n is low: rom_addr=0, rsp_data=0, rsp_valid=0, last_grant=NREQ-1, stage-1 valid=0, and req_ready is forced to 0.
REQ-024 Assertion of rst_n mid-pipeline discards all in-flight requests; no rsp_valid is issued for them after release.
REQ-025 On the first edge after rst_n deasserts, requester 0 has top round-robin priority.

Configuration
REQ-026 Macro ROM_ARB_PRIO0_EN, when defined, gives requester 0 absolute priority: when req_valid[0] is high, it is accepted regardless of the pointer; last_grant is not updated on grants to 0; requesters 1..NREQ-1 are served round-robin among themselves.
REQ-027 When ROM_ARB_PRIO0_EN is undefined, all NREQ requesters are served by pure round-robin per REQ-014.

Verification
REQ-028 Reset released; req_valid=4'b0001, addr0=0x10, ROM[0x10]=0xA5 -> req_ready=0001 in cycle t; rsp_valid=0001 and rsp_data=0xA5 in cycle t+2.
REQ-029 req_valid=4'b1111 held for 8 cycles, ROM_ARB_PRIO0_EN undefined -> grant order 0,1,2,3,0,1,2,3; 8 consecutive responses with the matching data.
REQ-030 ROM_ARB_PRIO0_EN defined, req_valid=4'b1111 held for 4 cycles -> requester 0 is granted every cycle; requesters 1-3 see no req_ready.
REQ-031 ROM_ARB_PRIO0_EN defined, req_valid=4'b1110 -> grant order 1,2,3,1; requester 0 is then raised -> requester 0 is granted in the next cycle.
REQ-032 rst_n is pulled low one cycle after an acceptance -> no rsp_valid is seen after release; the first post-reset grant goes to the lowest valid index.
REQ-033 Requester 2 alone issues addresses 0xFF then 0x00 back-to-back -> responses carry ROM[0xFF] and then ROM[0x00] in consecutive cycles, with rsp_valid=0100 on both.
